// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory port arbiter.
// State encoding and port indices.
package dm_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// Ties go to the port that was not granted last.
module rr_pick2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    unique case (1'b1)
      (&req):
        pick = (last == P_DMA) ? 2'b01 : 2'b10;
      (req[0] & ~req[1]):
        pick = 2'b01;
      (req[1] & ~req[0]):
        pick = 2'b10;
      default:
        pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares dm_4k between the CPU MEM stage (port 0) and the DMA (port 1).
// Round-robin with bounded locked bursts; 1-cycle registered read return.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  // burst_cnt excludes the IDLE grant that opened the burst
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             last_q;
  logic             last_d;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       req;
  logic [1:0]       lock;
  logic [1:0]       pick;
  logic [1:0]       gnt_raw;
  logic [1:0]       gnt;
  logic             own;
  logic             win;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};
  assign own  = (state_q == ST_OWN1);
  assign win  = pick[1];

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  assign cnt_inc = (burst_cnt == CNT_MAX) ? burst_cnt
                                          : burst_cnt + 1'b1;

  always_comb begin
    gnt_raw = 2'b00;
    state_d = state_q;
    cnt_d   = burst_cnt;
    case (state_q)
      ST_OWN0, ST_OWN1: begin
        gnt_raw[own] = req[own];
        if (req[own])
          cnt_d = cnt_inc;
        if (!req[own] || !lock[own] ||
            (cnt_inc >= CNT_LIM && req[~own]))
          state_d = ST_IDLE;
      end
      default: begin
        gnt_raw = pick;
        cnt_d   = '0;
        state_d = ST_IDLE;
        if ((|pick) && lock[win] &&
            (MAX_BURST > 1 || !req[~win]))
          state_d = win ? ST_OWN1 : ST_OWN0;
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (|gnt_raw)
      last_d = gnt_raw[1];
  end

  assign gnt       = gnt_raw & {2{~rst}};
  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign cpu_stall = req0 & ~gnt0;

  assign mem_we   = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr = gnt1 ? addr1 : addr0;
  assign mem_din  = gnt1 ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= P_DMA;
      burst_cnt <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_cnt <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0)
        rdata0 <= mem_dout;
      if (gnt1 & ~we1)
        rdata1 <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter.
// Directed table, corner sequences and a random run against a reference model.
module tb_dm_port_arbiter;

  localparam int MAXB = 8;

  logic        clk;
  logic        rst;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, cpu_stall, mem_we;
  logic [31:0] rdata0, rdata1, mem_din, mem_dout;
  logic [9:0]  mem_addr;
  logic        mem_clr;

  logic [31:0] mem [0:1023];
  logic [31:0] mref [0:1023];

  int n_chk;
  int n_fail;

  dm_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .lock0(lock0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .cpu_stall(cpu_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  // reference model: owner of a locked burst, burst length, last winner
  int          m_owner;
  int          m_run;
  int          m_last;
  int          m_g;
  logic        m_pv0, m_pv1;
  logic [31:0] m_pd0, m_pd1;

  typedef struct {
    logic r0, w0, l0; logic [9:0] a0; logic [31:0] d0;
    logic r1, w1, l1; logic [9:0] a1; logic [31:0] d1;
    logic g0, g1, st, rv0; logic [31:0] rd0; logic rv1;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r0, w0, l0, input logic [9:0] a0,
                        input logic [31:0] d0,
                        input logic r1, w1, l1, input logic [9:0] a1,
                        input logic [31:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1; m_g = -1;
    m_pv0 = 0; m_pv1 = 0; m_pd0 = '0; m_pd1 = '0;
    for (int i = 0; i < 1024; i++) mref[i] = '0;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_eval();
    m_g = -1;
    if (m_owner == 0) m_g = req0 ? 0 : -1;
    else if (m_owner == 1) m_g = req1 ? 1 : -1;
    else if (req0 && req1) m_g = (m_last == 1) ? 0 : 1;
    else if (req0) m_g = 0;
    else if (req1) m_g = 1;
  endtask

  task automatic model_commit();
    logic other_req;
    logic win_lock;
    m_pv0 = (m_g == 0) && !we0;
    m_pv1 = (m_g == 1) && !we1;
    if (m_pv0) m_pd0 = mref[addr0];
    if (m_pv1) m_pd1 = mref[addr1];
    if (m_g == 0 && we0) mref[addr0] = wdata0;
    if (m_g == 1 && we1) mref[addr1] = wdata1;
    other_req = (m_g == 0) ? req1 : req0;
    win_lock  = (m_g == 0) ? lock0 : lock1;
    if (m_owner >= 0) begin
      if (m_g < 0 || !win_lock) begin
        m_owner = -1;
      end else begin
        m_run++;
        if (m_run >= MAXB && other_req) m_owner = -1;
      end
    end else if (m_g >= 0) begin
      m_run = 1;
      if (win_lock && !(m_run >= MAXB && other_req)) m_owner = m_g;
    end
    if (m_g >= 0) m_last = m_g;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    mem_clr = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    tbl[0] = '{1,1,0,10'h004,32'hDEADBEEF, 0,0,0,10'h000,32'h0,
               1,0,0,0,32'h0,0};
    tbl[1] = '{1,0,0,10'h004,32'h0, 0,0,0,10'h000,32'h0,
               1,0,0,0,32'h0,0};
    tbl[2] = '{0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0,
               0,0,0,1,32'hDEADBEEF,0};
    tbl[3] = '{1,0,0,10'h3FC,32'h0, 1,1,0,10'h3FC,32'h12345678,
               0,1,1,0,32'hDEADBEEF,0};
    tbl[4] = '{1,0,0,10'h3FC,32'h0, 0,0,0,10'h000,32'h0,
               1,0,0,0,32'hDEADBEEF,0};
    tbl[5] = '{0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0,
               0,0,0,1,32'h12345678,0};
    tbl[6] = '{1,0,0,10'h000,32'h0, 1,0,0,10'h000,32'h0,
               0,1,1,0,32'h12345678,0};
    tbl[7] = '{1,0,0,10'h000,32'h0, 1,0,0,10'h000,32'h0,
               1,0,0,0,32'h12345678,1};
    tbl[8] = '{1,0,0,10'h000,32'h0, 1,0,0,10'h000,32'h0,
               0,1,1,1,32'h0,0};

    @(negedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);
    do_reset();

    // directed table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_in(tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
             tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("tbl%0d_stall", i), cpu_stall, tbl[i].st);
      chk($sformatf("tbl%0d_rvalid0", i), rvalid0, tbl[i].rv0);
      chk($sformatf("tbl%0d_rdata0", i), rdata0, tbl[i].rd0);
      chk($sformatf("tbl%0d_rvalid1", i), rvalid1, tbl[i].rv1);
      chk($sformatf("tbl%0d_mem_we", i), mem_we,
          (tbl[i].g0 & tbl[i].w0) | (tbl[i].g1 & tbl[i].w1));
    end

    // contention without lock from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_in(1, 0, 0, 10'h010, 0, 1, 0, 0, 10'h020, 0);
      #1;
      chk($sformatf("cont%0d_gnt0", i), gnt0, (i % 2) == 0);
      chk($sformatf("cont%0d_gnt1", i), gnt1, (i % 2) == 1);
      chk($sformatf("cont%0d_stall", i), cpu_stall, (i % 2) == 1);
    end

    // locked DMA burst while the CPU waits
    do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 10'h040, 0);
    #1;
    chk("burst_first_gnt1", gnt1, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(1, 0, 0, 10'h044, 0, 1, 0, 1, 10'h040, 0);
      #1;
      chk($sformatf("burst%0d_gnt1", i), gnt1, i < 7);
      chk($sformatf("burst%0d_gnt0", i), gnt0, i == 7);
      chk($sformatf("burst%0d_both", i), gnt0 & gnt1, 0);
    end

    // lock with the other port idle: no burst limit
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 1, 0, 1, 10'h050, 0);
      #1;
      chk($sformatf("lone%0d_gnt1", i), gnt1, 1);
    end
    chk("lone_cnt_sat", 32'(dut.burst_cnt), MAXB);

    // async reset between read grant and read return
    do_reset();
    @(negedge clk);
    set_in(1, 1, 0, 10'h008, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(1, 0, 0, 10'h008, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("pre_rst_rvalid0", rvalid0, 1);
    chk("pre_rst_rdata0", rdata0, 32'hCAFEF00D);
    set_in(1, 0, 0, 10'h008, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt0", gnt0, 0);
    chk("mid_rst_rdata0", rdata0, 0);
    @(negedge clk);
    #1;
    chk("mid_rst_rvalid0", rvalid0, 0);
    chk("mid_rst_state", 32'(dut.state_q), 0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 0, 0, 10'h008, 0, 1, 0, 0, 10'h00C, 0);
    #1;
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1", gnt1, 0);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      set_in($urandom_range(0, 9) < 6, $urandom_range(0, 1),
             $urandom_range(0, 9) < 4, 10'($urandom_range(0, 15)),
             $urandom,
             $urandom_range(0, 9) < 6, $urandom_range(0, 1),
             $urandom_range(0, 9) < 5, 10'($urandom_range(0, 15)),
             $urandom);
      #1;
      model_eval();
      chk("rnd_gnt0", gnt0, m_g == 0);
      chk("rnd_gnt1", gnt1, m_g == 1);
      chk("rnd_stall", cpu_stall, req0 && (m_g != 0));
      chk("rnd_mem_we", mem_we,
          (m_g == 0 && we0) || (m_g == 1 && we1));
      if (m_g >= 0)
        chk("rnd_mem_addr", mem_addr, (m_g == 1) ? addr1 : addr0);
      chk("rnd_rvalid0", rvalid0, m_pv0);
      chk("rnd_rvalid1", rvalid1, m_pv1);
      chk("rnd_rdata0", rdata0, m_pd0);
      chk("rnd_rdata1", rdata1, m_pd1);
      model_commit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
